// File: rtl/bp_me_nonsynth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_nonsynth_pkg
// Description : Shared types for the LCE trace-replay driver: trace opcodes,
//               driver FSM states, trace-packet and ROM-entry struct macros.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef BP_ME_NONSYNTH_PKG_MACROS
`define BP_ME_NONSYNTH_PKG_MACROS

// Width of one trace-replay packet: 4-bit command, physical address, data word
`define BP_ME_NONSYNTH_LCE_TR_PKT_WIDTH(paddr_width_mp, dword_width_mp) \
  (4 + (paddr_width_mp) + (dword_width_mp))

`define DECLARE_BP_ME_NONSYNTH_LCE_TR_PKT_S(paddr_width_mp, dword_width_mp) \
  typedef struct packed {                                                     \
    logic [3:0]                cmd;                                           \
    logic [paddr_width_mp-1:0] paddr;                                         \
    logic [dword_width_mp-1:0] data;                                          \
  } bp_me_nonsynth_lce_tr_pkt_s

// A ROM entry is the opcode stacked directly above a full trace packet
`define DECLARE_BP_ME_NONSYNTH_TR_ROM_ENTRY_S \
  typedef struct packed {                     \
    bp_me_nonsynth_tr_op_e      op;           \
    bp_me_nonsynth_lce_tr_pkt_s payload;      \
  } bp_me_nonsynth_tr_rom_entry_s

`endif

package bp_me_nonsynth_pkg;

  typedef enum logic [3:0] {
    e_tr_op_nop  = 4'b0000,
    e_tr_op_send = 4'b0001,
    e_tr_op_recv = 4'b0010,
    e_tr_op_wait = 4'b0011,
    e_tr_op_done = 4'b1111
  } bp_me_nonsynth_tr_op_e;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_SEND   = 3'd3,
    S_RECV   = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } bp_me_nonsynth_tr_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_me_nonsynth_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_nonsynth_sat_counter
// Description : Clear/up counter that sticks at all-ones instead of wrapping.
//               Clear has priority; a simultaneous up counts from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_nonsynth_sat_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  // Next count: optional clear, then a saturating increment
  always_comb begin
    count_d = clear_i ? '0 : count_q;
    if (up_i && (count_d != '1)) begin
      count_d = count_d + width_p'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bp_me_nonsynth_lce_tr_driver.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_nonsynth_lce_tr_driver
// Description : Trace-replay driver for the mock LCE harness. Walks a
//               synchronous trace ROM, issues command packets, checks the
//               LCE responses and reports done / error / timeout / mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_nonsynth_lce_tr_driver
  import bp_me_nonsynth_pkg::*;
#(
  parameter  int paddr_width_p     = 40,
  parameter  int dword_width_p     = 64,
  parameter  int rom_addr_width_p  = 10,
  parameter  int timeout_p         = 4096,
  parameter  int stop_on_error_p   = 1,
  localparam int tr_ring_width_lp  = `BP_ME_NONSYNTH_LCE_TR_PKT_WIDTH(paddr_width_p, dword_width_p),
  localparam int rom_data_width_lp = 4 + tr_ring_width_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  output logic [rom_addr_width_p-1:0]  rom_addr_o,
  input  logic [rom_data_width_lp-1:0] rom_data_i,
  output logic [tr_ring_width_lp-1:0]  tr_pkt_o,
  output logic                         tr_pkt_v_o,
  input  logic                         tr_pkt_yumi_i,
  input  logic [tr_ring_width_lp-1:0]  tr_pkt_i,
  input  logic                         tr_pkt_v_i,
  output logic                         tr_pkt_ready_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         timeout_o,
  output logic [15:0]                  mismatch_count_o
);

  `DECLARE_BP_ME_NONSYNTH_LCE_TR_PKT_S(paddr_width_p, dword_width_p);
  `DECLARE_BP_ME_NONSYNTH_TR_ROM_ENTRY_S;

  // Wide enough to hold timeout_p-1
  localparam int tmo_width_lp = $clog2(timeout_p) + 1;

  bp_me_nonsynth_tr_state_e     state_q, state_d;
  logic [rom_addr_width_p-1:0]  pc_q, pc_d;
  bp_me_nonsynth_tr_rom_entry_s entry_q, entry_d;
  bp_me_nonsynth_tr_rom_entry_s rom_entry;
  logic [15:0]                  wait_cnt_q, wait_cnt_d;
  logic                         timeout_q, timeout_d;
  logic                         advance;
  logic                         tmo_clear, tmo_up, mis_up;
  logic [tmo_width_lp-1:0]      tmo_cnt;

  assign rom_entry = rom_data_i;

  // Cycles spent in RECV without a response
  bp_me_nonsynth_sat_counter #(.width_p(tmo_width_lp)) u_tmo_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (tmo_clear),
    .up_i      (tmo_up),
    .count_o   (tmo_cnt)
  );

  // Responses that differed from the expected packet
  bp_me_nonsynth_sat_counter #(.width_p(16)) u_mis_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (1'b0),
    .up_i      (mis_up),
    .count_o   (mismatch_count_o)
  );

  // Next-state and handshake outputs; "advance" moves to the next trace entry
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    entry_d        = entry_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    advance        = 1'b0;
    tmo_clear      = 1'b0;
    tmo_up         = 1'b0;
    mis_up         = 1'b0;
    tr_pkt_v_o     = 1'b0;
    tr_pkt_ready_o = 1'b0;
    tr_pkt_o       = '0;

    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        entry_d = rom_entry;
        case (rom_entry.op)
          e_tr_op_nop:  advance = 1'b1;
          e_tr_op_send: state_d = S_SEND;
          e_tr_op_recv: begin
            state_d   = S_RECV;
            tmo_clear = 1'b1;
          end
          e_tr_op_wait: begin
            state_d    = S_WAIT;
            wait_cnt_d = rom_entry.payload.data[15:0];
          end
          e_tr_op_done: state_d = S_DONE;
          default:      state_d = S_ERROR;
        endcase
      end
      S_SEND: begin
        tr_pkt_v_o = 1'b1;
        tr_pkt_o   = entry_q.payload;
        if (tr_pkt_yumi_i) advance = 1'b1;
      end
      S_RECV: begin
        tr_pkt_ready_o = 1'b1;
        // A response landing on the threshold cycle takes precedence
        if (tr_pkt_v_i) begin
          if (tr_pkt_i == entry_q.payload) begin
            advance = 1'b1;
          end else begin
            mis_up = 1'b1;
            if (stop_on_error_p != 0) state_d = S_ERROR;
            else                      advance = 1'b1;
          end
        end else if (tmo_cnt == tmo_width_lp'(timeout_p - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end else begin
          tmo_up = 1'b1;
        end
      end
      S_WAIT: begin
        // A count of 0 or 1 both spend exactly one cycle here
        if (wait_cnt_q <= 16'd1) advance = 1'b1;
        else                     wait_cnt_d = wait_cnt_q - 16'd1;
      end
      S_DONE:   state_d = S_DONE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // Running off the end of the ROM is an error; pc never wraps to 0
    if (advance) begin
      if (&pc_q) begin
        state_d = S_ERROR;
      end else begin
        pc_d    = pc_q + rom_addr_width_p'(1);
        state_d = S_FETCH;
      end
    end
  end

  // Driver state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_RESET;
      pc_q       <= '0;
      entry_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      entry_q    <= entry_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rom_addr_o = pc_q;
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERROR);
  assign timeout_o  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_me_nonsynth_lce_tr_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_me_nonsynth_lce_tr_driver
// Description : Self-checking bench for the LCE trace-replay driver. Instance
//               A (stop on error, timeout 16) runs against an LCE model;
//               instance B (continue on error) replays a fixed bad-RECV trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_nonsynth_lce_tr_driver;

  localparam int PA_W  = 40;
  localparam int DW_W  = 64;
  localparam int PKT_W = 4 + PA_W + DW_W;
  localparam int ROM_W = 4 + PKT_W;
  localparam int AW    = 10;
  localparam int TMO   = 16;

  typedef struct {
    int               dly;
    logic [PKT_W-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic [AW-1:0]    rom_addr_a;
  logic [ROM_W-1:0] rom_data_a;
  logic [PKT_W-1:0] pkt_o_a;
  logic             v_o_a, ready_a, done_a, error_a, timeout_a;
  logic [15:0]      mis_a;
  logic             yumi_a = 1'b0;
  logic             v_i_a = 1'b0;
  logic [PKT_W-1:0] rsp_data_a = '0;

  // Instance B signals
  logic [AW-1:0]    rom_addr_b;
  logic [ROM_W-1:0] rom_data_b;
  logic [PKT_W-1:0] pkt_o_b;
  logic             v_o_b, ready_b, done_b, error_b, timeout_b;
  logic [15:0]      mis_b;

  logic [ROM_W-1:0] rom_a [0:(1<<AW)-1];
  logic [ROM_W-1:0] rom_b [0:(1<<AW)-1];

  // LCE model state and scoreboard queues
  int               yumi_dly = 0;
  int               ycnt = 0;
  int               rcnt = 0;
  int               rsp_hs = 0;
  bit               hs_pending = 1'b0;
  rsp_t             rsp_q[$];
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] obs_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  bp_me_nonsynth_lce_tr_driver #(
    .paddr_width_p(PA_W), .dword_width_p(DW_W), .rom_addr_width_p(AW),
    .timeout_p(TMO), .stop_on_error_p(1)
  ) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .tr_pkt_o(pkt_o_a), .tr_pkt_v_o(v_o_a), .tr_pkt_yumi_i(yumi_a),
    .tr_pkt_i(rsp_data_a), .tr_pkt_v_i(v_i_a), .tr_pkt_ready_o(ready_a),
    .done_o(done_a), .error_o(error_a), .timeout_o(timeout_a), .mismatch_count_o(mis_a)
  );

  bp_me_nonsynth_lce_tr_driver #(
    .paddr_width_p(PA_W), .dword_width_p(DW_W), .rom_addr_width_p(AW),
    .timeout_p(TMO), .stop_on_error_p(0)
  ) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .tr_pkt_o(pkt_o_b), .tr_pkt_v_o(v_o_b), .tr_pkt_yumi_i(1'b0),
    .tr_pkt_i({4'h2, 40'h100, 64'hBEEF}), .tr_pkt_v_i(1'b1), .tr_pkt_ready_o(ready_b),
    .done_o(done_b), .error_o(error_b), .timeout_o(timeout_b), .mismatch_count_o(mis_b)
  );

  // Synchronous trace ROMs
  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  // LCE model: yumi after yumi_dly cycles of valid; responses after dly RECV cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      yumi_a = 1'b0; v_i_a = 1'b0; ycnt = 0; rcnt = 0;
      hs_pending = 1'b0; rsp_hs = 0; obs_q.delete();
    end else begin
      if (v_o_a) begin
        if (ycnt >= yumi_dly) begin
          yumi_a = 1'b1;
          obs_q.push_back(pkt_o_a);
        end else begin
          yumi_a = 1'b0;
          ycnt++;
        end
      end else begin
        yumi_a = 1'b0;
        ycnt = 0;
      end
      if (hs_pending) begin
        v_i_a = 1'b0; hs_pending = 1'b0; rsp_hs++;
      end
      if (!v_i_a && ready_a && rsp_q.size() > 0) begin
        if (rcnt >= rsp_q[0].dly) begin
          v_i_a = 1'b1; rsp_data_a = rsp_q[0].data;
          void'(rsp_q.pop_front());
          rcnt = 0; hs_pending = 1'b1;
        end else begin
          rcnt++;
        end
      end
    end
  end

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [3:0] c, input logic [PA_W-1:0] a,
                                               input logic [DW_W-1:0] d);
    return {c, a, d};
  endfunction

  function automatic logic [ROM_W-1:0] mk_ent(input logic [3:0] op, input logic [PKT_W-1:0] p);
    return {op, p};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    yumi_dly = 0;
    exp_q.delete();
    rsp_q.delete();
    for (int i = 0; i < (1 << AW); i++) rom_a[i] = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (rom_addr_a !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %0h expected 0", rom_addr_a); end
    n_tests++; if (v_o_a !== 1'b0)    begin n_fail++; $display("FAIL rst_v_o: got %b expected 0", v_o_a); end
    n_tests++; if (ready_a !== 1'b0)  begin n_fail++; $display("FAIL rst_ready: got %b expected 0", ready_a); end
    n_tests++; if ({done_a, error_a, timeout_a} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {done_a, error_a, timeout_a}); end
    n_tests++; if (mis_a !== 16'd0)   begin n_fail++; $display("FAIL rst_mismatch: got %0d expected 0", mis_a); end
    n_tests++; if (pkt_o_a !== '0)    begin n_fail++; $display("FAIL rst_pkt_o: got %0h expected 0", pkt_o_a); end
  endtask

  task automatic test_send_recv();
    logic [PKT_W-1:0] pa, pr, e, o;
    int c;
    pa = mk_pkt(4'h1, 40'h1000, 64'h0123_4567_89AB_CDEF);
    pr = mk_pkt(4'h2, 40'h1000, 64'hFEDC_BA98_7654_3210);
    apply_reset();
    rom_a[0] = mk_ent(4'b0001, pa);
    rom_a[1] = mk_ent(4'b0010, pr);
    rom_a[2] = mk_ent(4'b1111, '0);
    exp_q.push_back(pa);
    yumi_dly = 2;
    rsp_q.push_back('{dly: 4, data: pr});
    release_reset();
    c = 0;
    while (!done_a && !error_a && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    n_tests++; if (c != 15) begin n_fail++; $display("FAIL sr_done_cycle: got %0d expected 15", c); end
    n_tests++; if ({done_a, error_a} !== 2'b10) begin n_fail++; $display("FAIL sr_flags: got %b expected 10", {done_a, error_a}); end
    n_tests++; if (mis_a !== 16'd0) begin n_fail++; $display("FAIL sr_mismatch: got %0d expected 0", mis_a); end
    n_tests++; if (rsp_hs != 1) begin n_fail++; $display("FAIL sr_rsp_handshakes: got %0d expected 1", rsp_hs); end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sr_send_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL sr_send_pkt: got %0h expected %0h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] p1, p2, e, o;
    int c, first, second;
    p1 = mk_pkt(4'h1, 40'hA0, 64'h1111);
    p2 = mk_pkt(4'h3, 40'hB0, 64'h2222);
    apply_reset();
    rom_a[0] = mk_ent(4'b0001, p1);
    rom_a[1] = mk_ent(4'b0001, p2);
    rom_a[2] = mk_ent(4'b1111, '0);
    exp_q.push_back(p1); exp_q.push_back(p2);
    release_reset();
    c = 0; first = -1; second = -1;
    while (!done_a && !error_a && c < 50) begin
      @(negedge clk); c++;
      if (v_o_a) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    n_tests++; if (first != 3) begin n_fail++; $display("FAIL b2b_first_send: got %0d expected 3", first); end
    n_tests++; if (second != 6) begin n_fail++; $display("FAIL b2b_second_send: got %0d expected 6", second); end
    n_tests++; if (c != 9 || !done_a) begin n_fail++; $display("FAIL b2b_done: got cycle %0d done %b expected 9 1", c, done_a); end
    @(negedge clk);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_send_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_send_pkt: got %0h expected %0h", o, e); end
    end
  endtask

  task automatic test_mismatch_stop();
    int c;
    apply_reset();
    rom_a[0] = mk_ent(4'b0010, mk_pkt(4'h2, 40'h100, 64'hDEAD));
    rom_a[1] = mk_ent(4'b1111, '0);
    rsp_q.push_back('{dly: 0, data: mk_pkt(4'h2, 40'h100, 64'hBEEF)});
    release_reset();
    c = 0;
    while (!done_a && !error_a && c < 50) begin @(negedge clk); c++; end
    repeat (10) @(negedge clk);
    n_tests++; if ({done_a, error_a, timeout_a} !== 3'b010) begin n_fail++; $display("FAIL mm_flags: got %b expected 010", {done_a, error_a, timeout_a}); end
    n_tests++; if (mis_a !== 16'd1) begin n_fail++; $display("FAIL mm_count: got %0d expected 1", mis_a); end
    n_tests++; if (rom_addr_a !== '0) begin n_fail++; $display("FAIL mm_pc_stuck: got %0h expected 0", rom_addr_a); end
  endtask

  task automatic test_no_stop();
    apply_reset();
    release_reset();
    repeat (40) @(negedge clk);
    n_tests++; if (mis_b !== 16'd3) begin n_fail++; $display("FAIL ns_count: got %0d expected 3", mis_b); end
    n_tests++; if ({done_b, error_b, timeout_b} !== 3'b100) begin n_fail++; $display("FAIL ns_flags: got %b expected 100", {done_b, error_b, timeout_b}); end
  endtask

  task automatic test_timeout();
    logic [PKT_W-1:0] px;
    int c, recv_cycles;
    px = mk_pkt(4'h2, 40'h200, 64'h5555);
    // No response at all
    apply_reset();
    rom_a[0] = mk_ent(4'b0010, px);
    rom_a[1] = mk_ent(4'b1111, '0);
    release_reset();
    c = 0; recv_cycles = 0;
    while (!done_a && !error_a && c < 100) begin
      @(negedge clk); c++;
      if (ready_a) recv_cycles++;
    end
    n_tests++; if (recv_cycles != TMO) begin n_fail++; $display("FAIL tmo_recv_cycles: got %0d expected %0d", recv_cycles, TMO); end
    n_tests++; if (c != 19) begin n_fail++; $display("FAIL tmo_error_cycle: got %0d expected 19", c); end
    n_tests++; if ({error_a, timeout_a, done_a} !== 3'b110) begin n_fail++; $display("FAIL tmo_flags: got %b expected 110", {error_a, timeout_a, done_a}); end
    n_tests++; if (mis_a !== 16'd0) begin n_fail++; $display("FAIL tmo_mismatch: got %0d expected 0", mis_a); end
    // Response on the 16th RECV cycle beats the threshold
    apply_reset();
    rom_a[0] = mk_ent(4'b0010, px);
    rom_a[1] = mk_ent(4'b1111, '0);
    rsp_q.push_back('{dly: TMO - 1, data: px});
    release_reset();
    c = 0;
    while (!done_a && !error_a && c < 100) begin @(negedge clk); c++; end
    n_tests++; if ({done_a, error_a, timeout_a} !== 3'b100 || c != 21) begin n_fail++; $display("FAIL tmo_edge: got flags %b cycle %0d expected 100 cycle 21", {done_a, error_a, timeout_a}, c); end
  endtask

  task automatic test_wait_illegal();
    int c, first;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      rom_a[0] = mk_ent(4'b0011, mk_pkt(4'h0, '0, (k == 0) ? 64'd0 : 64'd5));
      rom_a[1] = mk_ent(4'b0001, mk_pkt(4'h1, 40'h300, 64'h77));
      rom_a[2] = mk_ent(4'b1111, '0);
      release_reset();
      c = 0; first = -1;
      while (!done_a && !error_a && c < 50) begin
        @(negedge clk); c++;
        if (v_o_a && first < 0) first = c;
      end
      n_tests++; if (first != ((k == 0) ? 6 : 10)) begin n_fail++; $display("FAIL wait_latency_%0d: got %0d expected %0d", k, first, (k == 0) ? 6 : 10); end
    end
    apply_reset();
    rom_a[0] = mk_ent(4'b0101, '0);
    release_reset();
    c = 0;
    while (!error_a && c < 20) begin @(negedge clk); c++; end
    n_tests++; if (c != 3 || done_a) begin n_fail++; $display("FAIL illegal_op: got error cycle %0d done %b expected 3 0", c, done_a); end
  endtask

  task automatic test_pc_wrap();
    int c;
    apply_reset();
    release_reset();
    c = 0;
    while (!done_a && !error_a && c < 3000) begin @(negedge clk); c++; end
    n_tests++; if (c != 2049 || !error_a) begin n_fail++; $display("FAIL wrap_error: got cycle %0d error %b expected 2049 1", c, error_a); end
    n_tests++; if (rom_addr_a !== {AW{1'b1}}) begin n_fail++; $display("FAIL wrap_pc_hold: got %0h expected 3ff", rom_addr_a); end
  endtask

  task automatic test_reset_mid_send();
    logic [PKT_W-1:0] p, e, o;
    int c, first;
    p = mk_pkt(4'h1, 40'h400, 64'hCAFE);
    apply_reset();
    rom_a[0] = mk_ent(4'b0001, p);
    rom_a[1] = mk_ent(4'b1111, '0);
    exp_q.push_back(p);
    yumi_dly = 1000;
    release_reset();
    c = 0;
    while (!v_o_a && c < 20) begin @(negedge clk); c++; end
    n_tests++; if (!v_o_a) begin n_fail++; $display("FAIL rms_send_start: got v_o %b expected 1", v_o_a); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({v_o_a, ready_a} !== 2'b00) begin n_fail++; $display("FAIL rms_async_drop: got %b expected 00", {v_o_a, ready_a}); end
    yumi_dly = 0;
    @(negedge clk);
    release_reset();
    c = 0; first = -1;
    while (!done_a && !error_a && c < 50) begin
      @(negedge clk); c++;
      if (v_o_a && first < 0) first = c;
    end
    n_tests++; if (first != 3 || !done_a) begin n_fail++; $display("FAIL rms_reissue: got send cycle %0d done %b expected 3 1", first, done_a); end
    @(negedge clk);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rms_send_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++; if (o !== e) begin n_fail++; $display("FAIL rms_send_pkt: got %0h expected %0h", o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
    end
    for (int i = 0; i < 3; i++) rom_b[i] = mk_ent(4'b0010, mk_pkt(4'h2, 40'h100, 64'hDEAD));
    rom_b[3] = mk_ent(4'b1111, '0);
    test_reset();
    test_send_recv();
    test_back_to_back();
    test_mismatch_stop();
    test_no_stop();
    test_timeout();
    test_wait_illegal();
    test_pc_wrap();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bp_me_nonsynth_lce_tr_driver.md
Name: bp_me_nonsynth_lce_tr_driver

Overview:
- Trace-replay driver for the mock LCE test harness; it sits directly upstream of the LCE under test.
- Fetches trace entries from a synchronous ROM.
- Issues command packets on the LCE trace-replay input port and consumes LCE trace-replay responses.
- Compares each response against the expected packet and reports done, timeout and mismatch status to the testbench.
- The LCE tracer snoops the same tr_pkt handshakes this block drives and accepts.

Parameters:
- bp_params_p, e_bp_half_core_cfg: processor config; supplies paddr_width_p and dword_width_p.
- rom_addr_width_p, 10: trace ROM address width.
- timeout_p, 4096: max cycles spent in RECV before a timeout error.
- stop_on_error_p, 1: 1 = halt in ERROR on first mismatch; 0 = count the mismatch and continue.
- tr_ring_width_lp (localparam): `bp_me_nonsynth_lce_tr_pkt_width(paddr_width_p, dword_width_p).
- rom_data_width_lp (localparam): 4 + tr_ring_width_lp (4-bit opcode above the payload).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- rom_addr_o  out  rom_addr_width_p  trace ROM read address.
- rom_data_i  in  rom_data_width_lp  ROM data, valid one cycle after the address.
- tr_pkt_o  out  tr_ring_width_lp  command packet to the LCE.
- tr_pkt_v_o  out  1  command valid.
- tr_pkt_yumi_i  in  1  LCE consumes the command.
- tr_pkt_i  in  tr_ring_width_lp  response packet from the LCE.
- tr_pkt_v_i  in  1  response valid.
- tr_pkt_ready_o  out  1  driver ready for a response.
- done_o  out  1  DONE opcode reached (sticky).
- error_o  out  1  entered ERROR (sticky).
- timeout_o  out  1  the error cause was a RECV timeout (sticky).
- mismatch_count_o  out  16  response mismatches, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous on reset_n_i low):
  - state=S_RESET; pc=0; all outputs 0, including rom_addr_o.
  - tr_pkt_v_o and tr_pkt_ready_o drop immediately, even mid-handshake.
  - No partial transaction is retried after reset.
- Opcodes (entry[rom_data_width_lp-1 -: 4]):
  - 4'b0000 NOP.
  - 4'b0001 SEND.
  - 4'b0010 RECV.
  - 4'b0011 WAIT; cycle count = payload[15:0].
  - 4'b1111 DONE.
  - Any other value: ERROR.
- FSM, one transition per cycle:
  - S_RESET -> S_FETCH on the first clock edge after reset_n_i is high.
  - S_FETCH: rom_addr_o=pc; -> S_DECODE.
  - S_DECODE: register rom_data_i into entry_r, then dispatch:
    - NOP: pc++ -> S_FETCH.
    - SEND -> S_SEND.
    - RECV -> S_RECV; clear the timeout counter.
    - WAIT -> S_WAIT; load wait_cnt.
    - DONE -> S_DONE.
    - illegal -> S_ERROR.
  - S_SEND: tr_pkt_v_o=1; tr_pkt_o=entry_r payload, held stable until yumi. On tr_pkt_yumi_i: pc++ -> S_FETCH. yumi is only legal while v_o=1; a yumi at any other time is ignored.
  - S_RECV: tr_pkt_ready_o=1. On tr_pkt_v_i, compare the full tr_pkt_i against the payload with ==:
    - equal: pc++ -> S_FETCH.
    - unequal: mismatch_count++ (saturating). If stop_on_error_p -> S_ERROR, else pc++ -> S_FETCH.
    - No v_i: tmo_cnt++. When tmo_cnt == timeout_p-1 with no v_i: timeout_o=1 -> S_ERROR.
    - v_i arriving in the same cycle as the timeout threshold: the response wins and no timeout is flagged.
  - S_WAIT:
    - wait_cnt==0 at decode: advance on the next cycle (1 cycle in S_WAIT).
    - Otherwise decrement each cycle; on 0: pc++ -> S_FETCH.
  - S_DONE: done_o=1; terminal until reset.
  - S_ERROR: error_o=1; terminal until reset.
- pc wrap: incrementing from all-ones without reaching DONE -> S_ERROR; pc holds and never wraps to 0.
- Responses presented outside S_RECV see ready_o=0; they are back-pressured, not flagged as errors.
- Latency:
  - Minimum 3 cycles per SEND (fetch, decode, send with yumi in the same cycle).
  - Minimum 3 cycles per RECV.
- Flow control: at most one command outstanding; RECV provides the ordering.

Decomposition:
- Shared package bp_me_nonsynth_pkg:
  - opcode enum bp_me_nonsynth_tr_op_e;
  - FSM state enum;
  - entry struct macro `declare_bp_me_nonsynth_tr_rom_entry_s.
- Reuse the existing tr_pkt struct macro.
- Sub-module: bsg_counter_clear_up-style saturating counter bp_me_nonsynth_sat_counter; it serves both the timeout and the mismatch counters.
- Everything else is a single FSM module.

Test Plan:
- ROM [SEND A, RECV A', DONE]; LCE model yumis after 2 cycles and returns A' after 5 -> one handshake each; done_o=1 at cycle ~14; mismatch_count_o=0.
- RECV expects data 64'hDEAD; model returns 64'hBEEF with stop_on_error_p=1 -> error_o=1, mismatch_count_o=1, done_o=0, state stuck.
- Same stimulus with stop_on_error_p=0 and three bad RECVs before DONE -> mismatch_count_o=3, done_o=1, error_o=0.
- RECV with no response and timeout_p=16 -> timeout_o=error_o=1 exactly 16 cycles after entering S_RECV; response on cycle 16 -> no timeout.
- WAIT 0 and WAIT 5 -> 1 and 5 cycles in S_WAIT; illegal opcode 4'b0101 -> error_o=1 next cycle.
- Assert reset_n_i low while tr_pkt_v_o=1 mid-SEND -> v_o=0 in the same cycle; after release the replay restarts at pc=0 and the first SEND is reissued.
